// File: rtl/serctl_regbank.sv
`default_nettype none
// ============================================================================
//  Module      : serctl_regbank
//  Description : 8N1 serial control port. Receives framed commands
//                (IDENT, CMD, [DH, DL], CHK), writes/reads a bank of 16-bit
//                registers or external status channels, and answers each
//                decoded frame with an ACK or NACK response frame.
//  Revision    : 1.0  initial release
// ============================================================================
module serctl_regbank #(
    parameter int               HALF_BIT  = 3418,
    parameter int               NREG      = 8,
    parameter int               NSTAT     = 4,
    parameter int               TOUT_BITS = 11,
    parameter logic [7:0]       IDENT     = 8'hE7,
    parameter logic [16*NREG-1:0] RST_VAL = {NREG{16'h0000}}
) (
    input  logic                 clk,
    input  logic                 init,
    input  logic                 rxd,
    output logic                 txd,
    output logic [16*NREG-1:0]   reg_q,
    output logic                 wr_stb,
    output logic [3:0]           wr_addr,
    output logic                 st_rd,
    output logic [3:0]           st_addr,
    input  logic [15:0]          st_data,
    output logic                 busy,
    output logic [7:0]           err_cnt
);

    // HALF_BIT must be at least 3 so the response lead-in fits after PROC.
    localparam int c_TOUT_CYC = TOUT_BITS * 2 * HALF_BIT;
    localparam int c_CNT_W    = $clog2(c_TOUT_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(HALF_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_M1  = c_CNT_W'(2 * HALF_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_TOUT_M1 = c_CNT_W'(c_TOUT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_WAIT_M1 = c_CNT_W'(HALF_BIT - 3);
    localparam logic [4:0]         c_NREG5   = 5'(NREG);
    localparam logic [4:0]         c_NSTAT5  = 5'(NSTAT);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_RX_START = 4'd1,
        S_RX_BITS  = 4'd2,
        S_RX_STOP  = 4'd3,
        S_RX_GAP   = 4'd4,
        S_PROC     = 4'd5,
        S_TX_WAIT  = 4'd6,
        S_TX_BYTE  = 4'd7,
        S_DISCARD  = 4'd8
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_rx_s1, r_rx_s2, r_rx_prev;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2:0]           r_bit_idx, r_byte_idx;
    logic [7:0]           r_shift, r_cmd, r_dh, r_dl, r_xor;
    logic [9:0]           r_tx_sh;
    logic [3:0]           r_tx_bit;
    logic [2:0]           r_tx_idx, r_tx_len;
    logic                 r_rsp_nack, r_rsp_read;
    logic [7:0]           r_rsp_code;
    logic [15:0]          r_rdata;
    logic                 r_wr_stb, r_st_rd, r_st_pend, r_busy;
    logic [3:0]           r_wr_addr, r_st_addr;
    logic [7:0]           r_err;

    logic                 w_start_edge, w_tick_half, w_tick_bit, w_tick_tout, w_tick_wait;
    logic                 w_rx_shift, w_byte_ok, w_err_inc, w_commit, w_tx_load, w_tx_shift;
    logic                 w_is_wr, w_is_rd, w_is_st, w_last_byte, w_wr_en, w_st_en;
    logic [7:0]           w_code, w_rsp_b1, w_rsp_b2, w_rsp_chk, w_tx_byte;
    logic [15:0]          w_reg_rd;
    logic [16*NREG-1:0]   w_reg_flat;

    assign w_start_edge = r_rx_prev & ~r_rx_s2;
    assign w_tick_half  = (r_cnt == c_HALF_M1);
    assign w_tick_bit   = (r_cnt == c_BIT_M1);
    assign w_tick_tout  = (r_cnt == c_TOUT_M1);
    assign w_tick_wait  = (r_cnt == c_WAIT_M1);

    assign w_is_wr     = (r_cmd[7:4] == 4'h1);
    assign w_is_rd     = (r_cmd[7:4] == 4'h5);
    assign w_is_st     = (r_cmd[7:4] == 4'h6);
    assign w_last_byte = (r_byte_idx == 3'd4) || ((r_byte_idx == 3'd2) && !w_is_wr);
    assign w_wr_en     = w_commit && (w_code == 8'h00) && w_is_wr;
    assign w_st_en     = w_commit && (w_code == 8'h00) && w_is_st;

    // Frame validation in priority order; r_shift holds the received CHK.
    always_comb begin
        w_code = 8'h00;
        if (r_shift != r_xor)
            w_code = 8'h01;
        else if (!(w_is_wr || w_is_rd || w_is_st))
            w_code = 8'h02;
        else if (w_is_st ? ({1'b0, r_cmd[3:0]} >= c_NSTAT5) : ({1'b0, r_cmd[3:0]} >= c_NREG5))
            w_code = 8'h03;
    end

    // Two-stage synchroniser plus previous-value flop for start-edge detect.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= rxd;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge init) begin
        if (init) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state decode and single-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_rx_shift  = 1'b0;
        w_byte_ok   = 1'b0;
        w_err_inc   = 1'b0;
        w_commit    = 1'b0;
        w_tx_load   = 1'b0;
        w_tx_shift  = 1'b0;
        case (r_state)
            S_IDLE:     if (w_start_edge) w_state_nxt = S_RX_START;
            S_RX_START: if (w_tick_half) w_state_nxt = r_rx_s2 ? S_IDLE : S_RX_BITS;
            S_RX_BITS:  if (w_tick_bit) begin
                            w_rx_shift = 1'b1;
                            if (r_bit_idx == 3'd7) w_state_nxt = S_RX_STOP;
                        end
            S_RX_STOP:  if (w_tick_bit) begin
                            if (!r_rx_s2 || ((r_byte_idx == 3'd0) && (r_shift != IDENT))) begin
                                w_err_inc   = 1'b1;
                                w_state_nxt = S_DISCARD;
                            end else if (w_last_byte) begin
                                w_commit    = 1'b1;
                                w_state_nxt = S_PROC;
                            end else begin
                                w_byte_ok   = 1'b1;
                                w_state_nxt = S_RX_GAP;
                            end
                        end
            S_RX_GAP:   if (w_start_edge)     w_state_nxt = S_RX_START;
                        else if (w_tick_tout) w_state_nxt = S_DISCARD;
            S_PROC:     w_state_nxt = S_TX_WAIT;
            S_TX_WAIT:  if (w_tick_wait) begin
                            w_tx_load   = 1'b1;
                            w_state_nxt = S_TX_BYTE;
                        end
            S_TX_BYTE:  if (w_tick_bit) begin
                            if (r_tx_bit == 4'd9 && r_tx_idx != r_tx_len) begin
                                w_tx_load = 1'b1;
                            end else begin
                                w_tx_shift = 1'b1;
                                if (r_tx_bit == 4'd9) w_state_nxt = S_IDLE;
                            end
                        end
            S_DISCARD:  if (w_tick_tout && r_rx_s2) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Shared cycle counter: restarts on every state change and bit boundary,
    // and while discarding it only accumulates uninterrupted idle-high time.
    always_ff @(posedge clk or posedge init) begin
        if (init)
            r_cnt <= '0;
        else if ((r_state != w_state_nxt) ||
                 (((r_state == S_RX_BITS) || (r_state == S_TX_BYTE)) && w_tick_bit) ||
                 ((r_state == S_DISCARD) && !r_rx_s2))
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + c_CNT_W'(1);
    end

    // Receive datapath: bit shifter, byte capture and running checksum.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_shift    <= 8'h00;
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 3'd0;
            r_xor      <= 8'h00;
            r_cmd      <= 8'h00;
            r_dh       <= 8'h00;
            r_dl       <= 8'h00;
        end else begin
            if (w_rx_shift) r_shift <= {r_rx_s2, r_shift[7:1]};
            if (r_state != S_RX_BITS) r_bit_idx <= 3'd0;
            else if (w_rx_shift)      r_bit_idx <= r_bit_idx + 3'd1;
            if (r_state == S_IDLE) begin
                r_byte_idx <= 3'd0;
                r_xor      <= 8'h00;
            end else if (w_byte_ok) begin
                r_byte_idx <= r_byte_idx + 3'd1;
                r_xor      <= r_xor ^ r_shift;
                case (r_byte_idx)
                    3'd1:    r_cmd <= r_shift;
                    3'd2:    r_dh  <= r_shift;
                    3'd3:    r_dl  <= r_shift;
                    default: ;
                endcase
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            logic [15:0] r_val;
            // Register gi loads the frame data on a valid write to its address.
            always_ff @(posedge clk or posedge init) begin
                if (init)
                    r_val <= RST_VAL[16*gi +: 16];
                else if (w_wr_en && (r_cmd[3:0] == 4'(gi)))
                    r_val <= {r_dh, r_dl};
            end
            assign w_reg_flat[16*gi +: 16] = r_val;
        end
    endgenerate

    // Register read mux, addressed by the command's low nibble.
    always_comb begin
        w_reg_rd = 16'h0000;
        for (int i = 0; i < NREG; i++)
            if (r_cmd[3:0] == 4'(i)) w_reg_rd = w_reg_flat[16*i +: 16];
    end

    // Commit results: strobes, response descriptor, read data and error count.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_wr_stb   <= 1'b0;
            r_wr_addr  <= 4'h0;
            r_st_rd    <= 1'b0;
            r_st_addr  <= 4'h0;
            r_st_pend  <= 1'b0;
            r_rsp_nack <= 1'b0;
            r_rsp_read <= 1'b0;
            r_rsp_code <= 8'h00;
            r_tx_len   <= 3'd0;
            r_rdata    <= 16'h0000;
            r_err      <= 8'h00;
            r_busy     <= 1'b0;
        end else begin
            r_wr_stb  <= w_wr_en;
            r_st_rd   <= w_st_en;
            r_st_pend <= r_st_rd;
            r_busy    <= (w_state_nxt != S_IDLE);
            if (w_wr_en) r_wr_addr <= r_cmd[3:0];
            if (w_st_en) r_st_addr <= r_cmd[3:0];
            if (w_commit) begin
                r_rsp_nack <= (w_code != 8'h00);
                r_rsp_read <= (w_code == 8'h00) && !w_is_wr;
                r_rsp_code <= w_code;
                r_tx_len   <= (w_code != 8'h00) ? 3'd4 : (w_is_wr ? 3'd3 : 3'd5);
                if (w_is_rd) r_rdata <= w_reg_rd;
            end
            if (r_st_pend) r_rdata <= st_data;
            if ((w_err_inc || (w_commit && (w_code != 8'h00))) && (r_err != 8'hFF))
                r_err <= r_err + 8'd1;
        end
    end

    // Response byte selection; the final byte is always the XOR checksum.
    always_comb begin
        w_rsp_b1  = r_rsp_nack ? 8'hEE : r_cmd;
        w_rsp_b2  = r_rsp_nack ? r_rsp_code : r_rdata[15:8];
        w_rsp_chk = IDENT ^ w_rsp_b1;
        if (r_rsp_nack) w_rsp_chk = w_rsp_chk ^ r_rsp_code;
        if (r_rsp_read) w_rsp_chk = w_rsp_chk ^ r_rdata[15:8] ^ r_rdata[7:0];
        if (r_tx_idx == (r_tx_len - 3'd1))
            w_tx_byte = w_rsp_chk;
        else begin
            case (r_tx_idx)
                3'd0:    w_tx_byte = IDENT;
                3'd1:    w_tx_byte = w_rsp_b1;
                3'd2:    w_tx_byte = w_rsp_b2;
                default: w_tx_byte = r_rdata[7:0];
            endcase
        end
    end

    // Transmit shifter: {stop, data, start}, refilled with ones so txd idles high.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_tx_sh  <= 10'h3FF;
            r_tx_bit <= 4'd0;
            r_tx_idx <= 3'd0;
        end else if (w_commit) begin
            r_tx_idx <= 3'd0;
        end else if (w_tx_load) begin
            r_tx_sh  <= {1'b1, w_tx_byte, 1'b0};
            r_tx_bit <= 4'd0;
            r_tx_idx <= r_tx_idx + 3'd1;
        end else if (w_tx_shift) begin
            r_tx_sh  <= {1'b1, r_tx_sh[9:1]};
            r_tx_bit <= r_tx_bit + 4'd1;
        end
    end

    assign txd     = r_tx_sh[0];
    assign reg_q   = w_reg_flat;
    assign wr_stb  = r_wr_stb;
    assign wr_addr = r_wr_addr;
    assign st_rd   = r_st_rd;
    assign st_addr = r_st_addr;
    assign busy    = r_busy;
    assign err_cnt = r_err;

endmodule
`default_nettype wire
